regfile_wb_ctrl: RTL and testbench

Writeback controller that owns the write port of the 32x32 integer register file. It takes ALU results and returning load data, and merges them into one registered write per cycle. Load results are sign- or zero-extended and byte-aligned before the write. It also keeps a per-register busy scoreboard for outstanding loads and gives decode a stall signal. It sits between the execute/LSU stages and the register file; its `regs_*` outputs connect directly to the register file's `regs_rd`/`regs_wen`/`regs_wdata`.

---
 rtl/regfile_wb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: merges ALU results and load returns into one write per cycle.
// Latency: an ALU or load result accepted at edge N drives regs_wen during cycle N+1.
// Backpressure: ALU always wins and is never stalled; load data waits via ld_rready; issue gated by ld_issue_ready.
module regfile_wb_ctrl #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_off,
  output logic        ld_issue_ready,
  input  logic        ld_rvalid,
  output logic        ld_rready,
  input  logic [31:0] ld_rdata,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
  output logic [4:0]  regs_rd,
  output logic        regs_wen,
  output logic [31:0] regs_wdata
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One outstanding load: where it goes and how to carve its data.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } lq_ent_t;

  lq_ent_t        lq_q [LQ_DEPTH];
  lq_ent_t        lq_d [LQ_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ld_issue_ready_q, ld_issue_ready_d;
  logic [31:0]    busy_q, busy_d;
  logic           regs_wen_q, regs_wen_d;
  logic [4:0]     regs_rd_q, regs_rd_d;
  logic [31:0]    regs_wdata_q, regs_wdata_d;

  lq_ent_t        head;
  lq_ent_t        new_ent;
  logic           push;
  logic           pop;
  logic [31:0]    ld_fmt;

  // Extract and extend the addressed byte/halfword; unknown load types write zero.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   fmt_load = {{24{b[7]}}, b};
      F3_LH:   fmt_load = {{16{h[15]}}, h};
      F3_LW:   fmt_load = w;
      F3_LBU:  fmt_load = {24'h0, b};
      F3_LHU:  fmt_load = {16'h0, h};
      default: fmt_load = 32'h0;
    endcase
  endfunction

  assign head      = lq_q[rd_ptr_q];
  assign new_ent   = '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};
  assign ld_rready = !alu_valid && (count_q != '0);
  assign push      = ld_issue && ld_issue_ready_q;
  assign pop       = ld_rvalid && ld_rready;
  assign ld_fmt    = fmt_load(ld_rdata, head.funct3, head.off);

  // Load queue bookkeeping: pointers, occupancy and the registered not-full flag.
  always_comb begin
    lq_d     = lq_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      lq_d[wr_ptr_q] = new_ent;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d          = count_q + CW'(push) - CW'(pop);
    ld_issue_ready_d = (count_d != FULL_CNT);
  end

  // Busy scoreboard: a new issue to a register overrides a same-cycle clear of it.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head.rd] = 1'b0;
    end
    if (push) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage select: ALU first, then an accepted load; idle cycles keep address/data.
  always_comb begin
    regs_wen_d   = 1'b0;
    regs_rd_d    = regs_rd_q;
    regs_wdata_d = regs_wdata_q;
    if (alu_valid) begin
      regs_wen_d   = (alu_rd != 5'd0);
      regs_rd_d    = alu_rd;
      regs_wdata_d = alu_wdata;
    end else if (pop) begin
      regs_wen_d   = (head.rd != 5'd0);
      regs_rd_d    = head.rd;
      regs_wdata_d = ld_fmt;
    end
  end

  // State registers; reset drops every in-flight load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      ld_issue_ready_q <= 1'b1;
      busy_q           <= '0;
      regs_wen_q       <= 1'b0;
      regs_rd_q        <= '0;
      regs_wdata_q     <= '0;
    end else begin
      lq_q             <= lq_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      ld_issue_ready_q <= ld_issue_ready_d;
      busy_q           <= busy_d;
      regs_wen_q       <= regs_wen_d;
      regs_rd_q        <= regs_rd_d;
      regs_wdata_q     <= regs_wdata_d;
    end
  end

  // Stall decode on RAW/WAW against outstanding loads, or RAW against the write still in flight.
  always_comb begin
    hazard_stall = busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd] ||
                   (regs_wen_q && (regs_rd_q != 5'd0) &&
                    ((regs_rd_q == dec_rs1) || (regs_rd_q == dec_rs2)));
  end

  assign ld_issue_ready = ld_issue_ready_q;
  assign regs_wen       = regs_wen_q;
  assign regs_rd        = regs_rd_q;
  assign regs_wdata     = regs_wdata_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: ALU writes, load formatting, hazards, arbitration, queue wrap, reset.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_off;
  logic        ld_issue_ready;
  logic        ld_rvalid;
  logic        ld_rready;
  logic [31:0] ld_rdata;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_stall;
  logic [4:0]  regs_rd;
  logic        regs_wen;
  logic [31:0] regs_wdata;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_ctrl #(.LQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_wdata      (alu_wdata),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_funct3(ld_issue_funct3),
    .ld_issue_off   (ld_issue_off),
    .ld_issue_ready (ld_issue_ready),
    .ld_rvalid      (ld_rvalid),
    .ld_rready      (ld_rready),
    .ld_rdata       (ld_rdata),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .hazard_stall   (hazard_stall),
    .regs_rd        (regs_rd),
    .regs_wen       (regs_wen),
    .regs_wdata     (regs_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_wen"}, 32'(regs_wen), 32'd1);
    chk({tag, "_rd"}, 32'(regs_rd), 32'(rd));
    chk({tag, "_wdata"}, regs_wdata, data);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ld_issue        = 1'b1;
    ld_issue_rd     = rd;
    ld_issue_funct3 = f3;
    ld_issue_off    = off;
    tick();
    ld_issue = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; ld_issue_funct3 = '0; ld_issue_off = '0;
    ld_rvalid = 1'b0; ld_rdata = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

    // Reset values
    tick(); tick();
    chk("rst_wen", 32'(regs_wen), 32'd0);
    chk("rst_rd", 32'(regs_rd), 32'd0);
    chk("rst_wdata", regs_wdata, 32'd0);
    chk("rst_rready", 32'(ld_rready), 32'd0);
    chk("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    rst_n = 1'b1;

    // ALU write, then idle, then write to x0
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk_wr("alu5", 5'd5, 32'hDEADBEEF);
    tick();
    chk("alu_idle_wen", 32'(regs_wen), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_x0_wen", 32'(regs_wen), 32'd0);

    // Load formatting: LB off3, LHU off2, LW
    issue(5'd1, 3'b000, 2'd3);
    issue(5'd2, 3'b101, 2'd2);
    issue(5'd3, 3'b010, 2'd0);
    ld_rvalid = 1'b1; ld_rdata = 32'h80F01234;
    #1 chk("fmt_rready", 32'(ld_rready), 32'd1);
    tick();
    chk_wr("fmt_lb", 5'd1, 32'hFFFFFF80);
    tick();
    chk_wr("fmt_lhu", 5'd2, 32'h000080F0);
    tick();
    ld_rvalid = 1'b0;
    chk_wr("fmt_lw", 5'd3, 32'h80F01234);
    #1 chk("fmt_empty_rready", 32'(ld_rready), 32'd0);

    // Stray return with an empty queue is ignored
    ld_rvalid = 1'b1;
    tick();
    ld_rvalid = 1'b0;
    chk("stray_wen", 32'(regs_wen), 32'd0);

    // Load to x0 consumes a handshake but never writes
    issue(5'd0, 3'b010, 2'd0);
    ld_rvalid = 1'b1;
    #1 chk("x0_rready", 32'(ld_rready), 32'd1);
    tick();
    ld_rvalid = 1'b0;
    chk("x0_wen", 32'(regs_wen), 32'd0);
    chk("x0_drained", 32'(ld_rready), 32'd0);

    // Hazard on an outstanding load to x7
    issue(5'd7, 3'b010, 2'd0);
    dec_rs2 = 5'd7;
    #1 chk("haz_raw", 32'(hazard_stall), 32'd1);
    tick();
    chk("haz_raw_hold", 32'(hazard_stall), 32'd1);
    dec_rs2 = 5'd0; dec_rd = 5'd7;
    #1 chk("haz_waw", 32'(hazard_stall), 32'd1);
    dec_rd = 5'd0; dec_rs2 = 5'd7;
    ld_rvalid = 1'b1; ld_rdata = 32'h00000055;
    tick();
    ld_rvalid = 1'b0;
    chk_wr("haz_ld7", 5'd7, 32'h00000055);
    chk("haz_wb_window", 32'(hazard_stall), 32'd1);
    tick();
    chk("haz_clear", 32'(hazard_stall), 32'd0);
    dec_rs2 = 5'd0;

    // Arbitration: ALU beats a pending load for 3 cycles
    issue(5'd9, 3'b010, 2'd0);
    ld_rvalid = 1'b1; ld_rdata = 32'h00000099;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_wdata = 32'hA0 + 32'(i);
      #1 chk($sformatf("arb_rready_%0d", i), 32'(ld_rready), 32'd0);
      tick();
      chk_wr($sformatf("arb_alu_%0d", i), 5'(10 + i), 32'hA0 + 32'(i));
    end
    alu_valid = 1'b0;
    #1 chk("arb_rready_go", 32'(ld_rready), 32'd1);
    tick();
    ld_rvalid = 1'b0;
    chk_wr("arb_load", 5'd9, 32'h00000099);

    // Fill the queue; an issue while full is dropped
    for (int i = 0; i < 4; i++) begin
      issue(5'(16 + i), 3'b010, 2'd0);
    end
    chk("full_not_ready", 32'(ld_issue_ready), 32'd0);
    issue(5'd30, 3'b010, 2'd0);
    chk("full_still", 32'(ld_issue_ready), 32'd0);

    // Interleaved returns and issues across the pointer wrap, then drain
    for (int k = 0; k < 10; k++) begin
      ld_rvalid = 1'b1; ld_rdata = 32'h1000 + 32'(k);
      tick();
      ld_rvalid = 1'b0;
      chk_wr($sformatf("wrap_%0d", k), 5'(16 + k), 32'h1000 + 32'(k));
      if (k < 6) begin
        chk($sformatf("wrap_ready_%0d", k), 32'(ld_issue_ready), 32'd1);
        issue(5'(20 + k), 3'b010, 2'd0);
      end
    end
    chk("wrap_drained", 32'(ld_rready), 32'd0);
    dec_rs1 = 5'd30;
    #1 chk("dropped_not_busy", 32'(hazard_stall), 32'd0);
    dec_rs1 = 5'd0;

    // Reset with loads in flight and a write pending
    issue(5'd3, 3'b010, 2'd0);
    issue(5'd4, 3'b010, 2'd0);
    alu_valid = 1'b1; alu_rd = 5'd8; alu_wdata = 32'h77;
    tick();
    alu_valid = 1'b0;
    chk("pre_rst_wen", 32'(regs_wen), 32'd1);
    dec_rs1 = 5'd3; dec_rs2 = 5'd4;
    #1 chk("pre_rst_stall", 32'(hazard_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(regs_wen), 32'd0);
    chk("mid_rst_issue_ready", 32'(ld_issue_ready), 32'd1);
    chk("mid_rst_rready", 32'(ld_rready), 32'd0);
    chk("mid_rst_stall", 32'(hazard_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    ld_rvalid = 1'b1; ld_rdata = 32'hBAD0BAD0;
    #1 chk("post_rst_rready", 32'(ld_rready), 32'd0);
    tick();
    ld_rvalid = 1'b0;
    chk("post_rst_wen", 32'(regs_wen), 32'd0);
    chk("post_rst_stall", 32'(hazard_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
